// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for ram_access_ctrl: FSM states, requester IDs and default widths.
package ram_access_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

endpackage

// File: rtl/ram_access_ctrl_rr_arbiter2.sv
// Two-requester arbiter producing a one-hot grant. ARB_ROUND_ROBIN_EN selects
// round-robin (alternate on contention); otherwise req[0] has fixed priority.
module rr_arbiter2
  import ram_access_ctrl_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_lastGrant;

  // Remember who won most recently; B is the reset value so A wins first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lastGrant <= ID_B;
    end else if (|gnt) begin
      r_lastGrant <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (r_lastGrant == ID_A) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end
`else
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/ram_access_ctrl.sv
// Controller for an external 64x8 single-port RAM: clears it after reset, then
// arbitrates A/B requests with 2-cycle read returns. Option: ARB_ROUND_ROBIN_EN.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  output logic              init_done,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_clrCnt;
  logic              r_initDone;
  logic              r_rdPend;
  logic              r_rdId;
  logic              r_aRvalid;
  logic              r_bRvalid;
  logic [DATA_W-1:0] r_aRdata;
  logic [DATA_W-1:0] r_bRdata;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_clrLast;
  logic              w_rdGrant;

  assign w_req     = (r_state == S_RUN) ? {b_valid, a_valid} : 2'b00;
  assign w_clrLast = (r_clrCnt == ADDR_W'(DEPTH - 1));

  rr_arbiter2 u_arb (
`ifdef ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .reset (reset),
`endif
    .req   (w_req),
    .gnt   (w_gnt)
  );

  assign a_ready   = w_gnt[0];
  assign b_ready   = w_gnt[1];
  assign init_done = r_initDone;
  assign a_rvalid  = r_aRvalid;
  assign b_rvalid  = r_bRvalid;
  assign a_rdata   = r_aRdata;
  assign b_rdata   = r_bRdata;

  // RAM pins come from the clear sweep or from whichever requester holds the grant.
  always_comb begin
    w_stateNext = r_state;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_data    = '0;
    w_rdGrant   = 1'b0;
    case (r_state)
      S_CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = r_clrCnt;
        if (w_clrLast) begin
          w_stateNext = S_RUN;
        end
      end
      S_RUN: begin
        if (w_gnt[0]) begin
          ram_we    = a_we;
          ram_addr  = a_addr;
          ram_data  = a_wdata;
          w_rdGrant = ~a_we;
        end else if (w_gnt[1]) begin
          ram_we    = b_we;
          ram_addr  = b_addr;
          ram_data  = b_wdata;
          w_rdGrant = ~b_we;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clrCnt   <= '0;
      r_initDone <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == S_CLEAR) begin
        r_clrCnt <= r_clrCnt + ADDR_W'(1);
        if (w_clrLast) begin
          r_initDone <= 1'b1;
        end
      end
    end
  end

  // Read granted in N is marked pending; RAM q is captured at the end of N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdPend  <= 1'b0;
      r_rdId    <= ID_A;
      r_aRvalid <= 1'b0;
      r_bRvalid <= 1'b0;
      r_aRdata  <= '0;
      r_bRdata  <= '0;
    end else begin
      r_rdPend  <= w_rdGrant;
      r_rdId    <= w_gnt[1] ? ID_B : ID_A;
      r_aRvalid <= r_rdPend && (r_rdId == ID_A);
      r_bRvalid <= r_rdPend && (r_rdId == ID_B);
      if (r_rdPend && (r_rdId == ID_A)) begin
        r_aRdata <= ram_q;
      end
      if (r_rdPend && (r_rdId == ID_B)) begin
        r_bRdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: external RAM model, reference memory
// and arbitration model, response scoreboard checked by a separate monitor.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init_done;
  logic              a_valid = 1'b0;
  logic              a_ready;
  logic              a_we = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              b_valid = 1'b0;
  logic              b_ready;
  logic              b_we = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  int checks = 0;
  int passes = 0;
  int cycleCount = 0;

  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
    int                due;
  } resp_t;

  resp_t             expQ[$];
  resp_t             monE;
  logic [DATA_W-1:0] refMem [DEPTH];
  int                lastWinner;

  logic [DATA_W-1:0] ramMem [DEPTH];
  logic [ADDR_W-1:0] ramRdAddr;

  ram_access_ctrl dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // External single-port RAM: q follows the last address presented without a write.
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_data;
    else        ramRdAddr <= ram_addr;
  end
  assign ram_q = ramMem[ramRdAddr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCount);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s (cycle %0d)", name, cycleCount);
  endtask

  // Monitor: every response must match the oldest outstanding read, on time.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].due < cycleCount) begin
      void'(expQ.pop_front());
      failNow("missing_rvalid");
    end
    if (a_rvalid === 1'b1 || b_rvalid === 1'b1) begin
      if (expQ.size() == 0) begin
        failNow("unexpected_rvalid");
      end else begin
        monE = expQ.pop_front();
        checkOutput("resp_cycle", cycleCount, monE.due);
        checkOutput("resp_a_rvalid", a_rvalid, monE.id == 0);
        checkOutput("resp_b_rvalid", b_rvalid, monE.id == 1);
        checkOutput("resp_rdata", (monE.id == 0) ? a_rdata : b_rdata, monE.data);
      end
    end
  end

  // One RUN cycle: drive both requesters, check grant and RAM pins, update the model.
  task automatic applyStimulus(input logic av, input logic aw, input logic [ADDR_W-1:0] aa,
                               input logic [DATA_W-1:0] ad, input logic bv, input logic bw,
                               input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
    int                win;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    win = -1;
    if (av && bv) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = (lastWinner == 0) ? 1 : 0;
`else
      win = 0;
`endif
    end else if (av) begin
      win = 0;
    end else if (bv) begin
      win = 1;
    end
    checkOutput("a_ready", a_ready, win == 0);
    checkOutput("b_ready", b_ready, win == 1);
    we   = (win == 1) ? bw : aw;
    addr = (win == 1) ? ba : aa;
    data = (win == 1) ? bd : ad;
    if (win < 0) begin
      we = 1'b0; addr = '0; data = '0;
    end
    checkOutput("ram_we", ram_we, we);
    checkOutput("ram_addr", ram_addr, addr);
    checkOutput("ram_data", ram_data, data);
    if (win >= 0) begin
      if (we) refMem[addr] = data;
      else    expQ.push_back('{id: win, data: refMem[addr], due: cycleCount + 2});
      lastWinner = win;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    expQ.delete();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    lastWinner = 1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_init_done", init_done, 0);
      checkOutput("rst_a_rvalid", a_rvalid, 0);
      checkOutput("rst_b_rvalid", b_rvalid, 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Requests are held valid during the sweep to confirm they are never accepted.
  task automatic sweepCheck(input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("clr_ram_we", ram_we, 1);
      checkOutput("clr_ram_addr", ram_addr, i);
      checkOutput("clr_ram_data", ram_data, 0);
      checkOutput("clr_init_done", init_done, 0);
      checkOutput("clr_a_ready", a_ready, 0);
      checkOutput("clr_b_ready", b_ready, 0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    if (full) begin
      @(negedge clk);
      checkOutput("init_done_set", init_done, 1);
      checkOutput("idle_ram_we", ram_we, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    doReset();
    sweepCheck(DEPTH, 1'b1);

    // Freshly cleared memory reads back as zero.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) applyStimulus(1, 0, ADDR_W'($urandom), '0, 0, 0, '0, '0);
      else            applyStimulus(0, 0, '0, '0, 1, 0, ADDR_W'($urandom), '0);
    end
    idle(2);

    applyStimulus(1, 1, 6'h03, 8'h5A, 0, 0, '0, '0);
    applyStimulus(1, 0, 6'h03, 8'h00, 0, 0, '0, '0);
    idle(2);

    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, ADDR_W'($urandom), '0, 1, 0, ADDR_W'($urandom), '0);
    idle(2);

    applyStimulus(1, 1, 6'h10, 8'h01, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 1, 6'h11, 8'h02);
    applyStimulus(1, 1, 6'h12, 8'h03, 0, 0, '0, '0);
    applyStimulus(1, 0, 6'h10, '0, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 6'h11, '0);
    applyStimulus(1, 0, 6'h12, '0, 0, 0, '0, '0);
    idle(2);

    applyStimulus(1, 1, 6'h20, 8'h77, 0, 0, '0, '0);
    applyStimulus(1, 0, 6'h20, '0, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 1, 6'h20, 8'h99);
    idle(1);
    applyStimulus(1, 0, 6'h20, '0, 0, 0, '0, '0);
    idle(2);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                    1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
    idle(3);
    checkOutput("queue_drained", expQ.size(), 0);

    // Reset one cycle after a read grant, then again part-way through the sweep.
    applyStimulus(1, 0, 6'h03, '0, 0, 0, '0, '0);
    doReset();
    sweepCheck(10, 1'b0);
    doReset();
    sweepCheck(DEPTH, 1'b1);
    applyStimulus(1, 0, 6'h03, '0, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 6'h20, '0);
    idle(3);
    checkOutput("queue_drained_end", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
